mem_access_unit: RTL

Load/store access unit for the MEM stage of the MIPS pipeline, sitting directly upstream of the 64×32 word-addressed data memory (`dmem`). It converts byte-addressed load/store requests of byte, halfword and word size into word accesses on the memory port. Loads return a sign- or zero-extended result one cycle later. Sub-word stores are performed as a two-cycle read-modify-write, stalling the pipeline for one cycle.

---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 65 ++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: MEM-stage request/response and dmem port bundle
// slave modport: the access unit; master modport: pipeline plus dmem side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    output stall, resp_valid, resp_rdata, misalign, mem_wr, mem_addr, mem_din
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    input  stall, resp_valid, resp_rdata, misalign, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit in front of a 64x32 word memory
// Ports: clk, rst_n (async active-low), bus (mem_access_unit_if.slave):
//   req_* request in, stall/resp_* out, mem_wr/mem_addr/mem_din/mem_dout dmem port.
// Option: MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t      state;
  logic [31:0] mbuf;
  logic [5:0]  alat;
  logic        is_word, is_half, is_byte, mis, acc;
  logic [4:0]  sh;
  logic [31:0] mask, wsh, ext;
  logic [15:0] lane;
  always_comb begin
    is_word = bus.req_size[1];
    is_half = bus.req_size == 2'b01;
    is_byte = bus.req_size == 2'b00;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    mis = (is_half & bus.req_addr[0]) | (is_word & |bus.req_addr[1:0]);
`else
    mis = 1'b0;
`endif
    acc = state == IDLE && bus.req_valid && !mis;
    // half lanes ignore addr[0], so an odd halfword address picks lane addr[1]
    sh = is_byte ? {bus.req_addr[1:0], 3'b000} : {bus.req_addr[1], 4'b0000};
    mask = (is_byte ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    wsh = bus.req_wdata << sh;
    lane = 16'(bus.mem_dout >> sh);
    ext = is_word ? bus.mem_dout
        : is_half ? {{16{~bus.req_unsigned & lane[15]}}, lane}
        : {{24{~bus.req_unsigned & lane[7]}}, lane[7:0]};
    bus.stall = acc && bus.req_we && !is_word;
    // combinational so an async reset in MERGE kills the pending write at once
    bus.mem_wr = state == MERGE || (acc && bus.req_we && is_word);
    bus.mem_addr = state == MERGE ? alat : bus.req_addr[7:2];
    bus.mem_din = state == MERGE ? (mbuf & ~mask) | (wsh & mask) : bus.req_wdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.misalign <= 1'b0;
      mbuf <= '0;
      alat <= '0;
    end else if (state == MERGE) begin
      state <= IDLE;
      bus.resp_valid <= 1'b1;
      bus.resp_rdata <= '0;
      bus.misalign <= 1'b0;
    end else begin
      bus.resp_valid <= bus.req_valid && !bus.stall;
      bus.misalign <= bus.req_valid && mis;
      if (bus.req_valid) bus.resp_rdata <= acc && !bus.req_we ? ext : '0;
      if (bus.stall) begin
        state <= MERGE;
        mbuf <= bus.mem_dout;
        alat <= bus.req_addr[7:2];
      end
    end
endmodule
